// File: rtl/avr_serial_tx.sv
// 8N1 transmitter toward the AVR's avr_rx pin, with a small byte FIFO and
// avr_rx_busy flow control sampled only between frames.
`timescale 1ns/1ps
module avr_serial_tx #(
  parameter int CLK_PER_BIT = 100,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  input  logic       rx_busy,
  output logic       busy,
  output logic [1:0] dbg_state
);
  // Handshake: a byte is pushed at a rising edge iff in_valid && in_ready;
  // in_valid may be held or dropped freely, in_ready depends only on the FIFO fill.

  localparam int CW = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;
  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] LAST_TICK = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] TICK_ONE  = CW'(1);
  localparam logic [AW:0]   FULL      = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   ctr_q, ctr_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            sync1_q, busy_sync_q;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  logic            push, pop, last;

  // Resets to "blocked" so nothing is sent before the AVR line is known.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      busy_sync_q <= 1'b1;
    end else begin
      sync1_q     <= rx_busy;
      busy_sync_q <= sync1_q;
    end
  end

  assign in_ready = (count_q != FULL);
  assign push     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ctr_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign last = (ctr_q == LAST_TICK);

  // tx_d is the line level for the state being entered, so tx is glitch-free.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q + TICK_ONE;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        ctr_d = ctr_q;
        tx_d  = 1'b1;
        if ((count_q != '0) && !busy_sync_q) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          ctr_d   = '0;
          bit_d   = '0;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (last) begin
          ctr_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (last) begin
          ctr_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (last) begin
          ctr_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ctr_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign tx        = tx_q;
  assign busy      = (state_q != IDLE) || (count_q != '0);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_avr_serial_tx.sv
// Bench for avr_serial_tx: table of single-byte frames, directed corner
// sequences, then random traffic against a frame-level reference model.
`timescale 1ns/1ps
module tb_avr_serial_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FLEN  = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       rx_busy = 1'b0;
  logic       in_ready, tx, busy;
  logic [1:0] dbg_state;

  int vec_cnt = 0;
  int err_cnt = 0;

  avr_serial_tx #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx(tx), .rx_busy(rx_busy), .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line level of frame slot idx (0 = start, 1..8 = data LSB first, 9 = stop).
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  task automatic push_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Called just after the START entry edge; returns just after the IDLE entry edge.
  task automatic check_frame(input string nm, input logic [7:0] b, input int raise_at);
    for (int j = 0; j < FLEN; j++) begin
      check(nm, tx, frame_bit(b, j / CPB));
      check({nm, "_busy"}, busy, 1'b1);
      if (j == raise_at) rx_busy = 1'b1;
      tick();
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic [7:0] exp_q[$];
  int         m_cnt = 0;
  int         m_pos = 0;
  bit         m_active = 1'b0;
  logic [7:0] m_shreg = 8'h00;
  logic       valid_prev = 1'b0;
  logic       ready_prev = 1'b1;
  logic [7:0] data_prev = 8'h00;
  logic       rb_hist [3] = '{1'b0, 1'b0, 1'b0};
  int         rate = 10;

  task automatic model_cycle(input bit drive_random);
    int idx;
    if (valid_prev && ready_prev) begin
      exp_q.push_back(data_prev);
      m_cnt++;
    end
    if (m_active) begin
      m_pos++;
      if (m_pos == FLEN) begin
        m_active = 1'b0;
      end else if (m_pos % CPB == CPB / 2) begin
        idx = m_pos / CPB;
        if (idx == 0) check("rnd_start_bit", tx, 1'b0);
        else if (idx <= 8) m_shreg[idx-1] = tx;
        else begin
          check("rnd_stop_bit", tx, 1'b1);
          if (exp_q.size() == 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL rnd_byte: got %0h, expected no frame at %0t", m_shreg, $time);
          end else begin
            check("rnd_byte", m_shreg, exp_q.pop_front());
          end
        end
      end
    end else if (tx === 1'b0) begin
      // A frame begins on the same edge its byte leaves the FIFO.
      m_active = 1'b1;
      m_pos    = 0;
      m_cnt--;
      check("rnd_flow_ctl", rb_hist[2], 1'b0);
    end
    check("rnd_in_ready", in_ready, (m_cnt != DEPTH));
    check("rnd_busy", busy, (m_active || m_cnt != 0));
    if (drive_random) begin
      in_valid = ($urandom_range(0, 99) < rate);
      in_data  = 8'($urandom);
      if ($urandom_range(0, 59) == 0) rx_busy = ~rx_busy;
    end else begin
      in_valid = 1'b0;
      rx_busy  = 1'b0;
    end
    valid_prev = in_valid;
    data_prev  = in_data;
    ready_prev = (m_cnt != DEPTH);
    rb_hist[2] = rb_hist[1];
    rb_hist[1] = rb_hist[0];
    rb_hist[0] = rx_busy;
    tick();
  endtask

  // ---------------- test sequence ----------------
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{8'hA5, 10'b1_10100101_0};
    tbl[1] = '{8'h00, 10'b1_00000000_0};
    tbl[2] = '{8'hFF, 10'b1_11111111_0};
    tbl[3] = '{8'h3C, 10'b1_00111100_0};
    tbl[4] = '{8'h01, 10'b1_00000001_0};
    tbl[5] = '{8'h80, 10'b1_10000000_0};

    // Reset values while held in reset.
    repeat (3) tick();
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_state", dbg_state, 2'd0);
    rst_n = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 50; i++) begin
      check("idle_tx", tx, 1'b1);
      check("idle_busy", busy, 1'b0);
      check("idle_in_ready", in_ready, 1'b1);
      tick();
    end

    // Table of single frames, FIFO empty, flow control open.
    foreach (tbl[i]) begin
      push_byte(tbl[i].data);
      check("tbl_push_tx", tx, 1'b1);
      check("tbl_push_busy", busy, 1'b1);
      tick();
      for (int j = 0; j < FLEN; j++) begin
        check("tbl_tx", tx, tbl[i].frame[j / CPB]);
        check("tbl_busy", busy, 1'b1);
        tick();
      end
      check("tbl_end_busy", busy, 1'b0);
      check("tbl_end_tx", tx, 1'b1);
      repeat (3) tick();
    end

    // FIFO full: fifth push dropped, four frames back to back after release.
    rx_busy = 1'b1;
    repeat (3) tick();
    for (int i = 1; i <= 5; i++) begin
      in_data  = 8'(i);
      in_valid = 1'b1;
      tick();
      check("full_in_ready", in_ready, (i < 4));
    end
    in_valid = 1'b0;
    repeat (10) begin
      check("full_hold_tx", tx, 1'b1);
      check("full_hold_busy", busy, 1'b1);
      tick();
    end
    rx_busy = 1'b0;
    tick();
    check("full_lat1_tx", tx, 1'b1);
    tick();
    check("full_lat2_tx", tx, 1'b1);
    tick();
    check("full_pop_in_ready", in_ready, 1'b1);
    for (int b = 1; b <= 4; b++) begin
      check_frame("full_frame", 8'(b), -1);
      check("full_gap_tx", tx, 1'b1);
      if (b < 4) begin
        check("full_gap_busy", busy, 1'b1);
        tick();
      end
    end
    check("full_done_busy", busy, 1'b0);
    repeat (50) begin
      check("full_drop_tx", tx, 1'b1);
      check("full_drop_busy", busy, 1'b0);
      tick();
    end

    // Flow control raised mid-frame.
    in_data  = 8'h3C;
    in_valid = 1'b1;
    tick();
    in_data = 8'hC3;
    tick();
    in_valid = 1'b0;
    check_frame("flow_frame0", 8'h3C, 2 * CPB + 2);
    repeat (20) begin
      check("flow_hold_tx", tx, 1'b1);
      check("flow_hold_busy", busy, 1'b1);
      tick();
    end
    rx_busy = 1'b0;
    tick();
    check("flow_lat1_tx", tx, 1'b1);
    tick();
    check("flow_lat2_tx", tx, 1'b1);
    tick();
    check_frame("flow_frame1", 8'hC3, -1);
    check("flow_done_busy", busy, 1'b0);
    repeat (3) tick();

    // Push on the pop edge with one byte queued.
    rx_busy = 1'b1;
    repeat (3) tick();
    push_byte(8'h5A);
    repeat (5) begin
      check("pp_hold_tx", tx, 1'b1);
      tick();
    end
    rx_busy = 1'b0;
    tick();
    tick();
    in_data  = 8'h96;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_frame("pp_frame0", 8'h5A, -1);
    check("pp_gap_tx", tx, 1'b1);
    check("pp_gap_busy", busy, 1'b1);
    tick();
    check_frame("pp_frame1", 8'h96, -1);
    check("pp_done_busy", busy, 1'b0);
    repeat (3) tick();

    // Reset during data bit 3 of 0xFF with another byte queued.
    push_byte(8'hFF);
    tick();
    push_byte(8'h00);
    repeat (16) tick();
    check("rstmid_pre_busy", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_tx", tx, 1'b1);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_in_ready", in_ready, 1'b1);
    check("rstmid_state", dbg_state, 2'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      check("rstmid_after_tx", tx, 1'b1);
      check("rstmid_after_busy", busy, 1'b0);
      tick();
    end

    // Random traffic against the reference model.
    for (int ph = 0; ph < 8; ph++) begin
      rate = $urandom_range(1, 40);
      for (int c = 0; c < 500; c++) model_cycle(1'b1);
    end
    for (int c = 0; c < 3000; c++) begin
      if (!m_active && m_cnt == 0 && exp_q.size() == 0 && !valid_prev) break;
      model_cycle(1'b0);
    end
    check("rnd_drain", exp_q.size() + m_cnt + int'(m_active), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
